// File: rtl/bubsys_snd_mixer_if.sv
// Sample-side bundle of the Bubble System sound mixer: channel samples, volume
// codes and strobe in; mixed stereo sample, valid pulse and overrun flag out.
interface bubsys_snd_mixer_if;
  logic        i_SAMPLE_CEN;
  logic [15:0] i_CH0;
  logic [15:0] i_CH1;
  logic [15:0] i_CH2;
  logic [15:0] i_CH3;
  logic [15:0] i_VOL;
  logic [15:0] o_SND_L;
  logic [15:0] o_SND_R;
  logic        o_SND_VALID;
  logic        o_OVERRUN;

  modport master (
    output i_SAMPLE_CEN, i_CH0, i_CH1, i_CH2, i_CH3, i_VOL,
    input  o_SND_L, o_SND_R, o_SND_VALID, o_OVERRUN
  );

  modport slave (
    input  i_SAMPLE_CEN, i_CH0, i_CH1, i_CH2, i_CH3, i_VOL,
    output o_SND_L, o_SND_R, o_SND_VALID, o_OVERRUN
  );
endinterface

// File: rtl/bubsys_snd_mixer.sv
// Four-channel volume-scaled mixer with one shared MAC and output saturation.
// Optional output low-pass stage enabled by defining BUBSYS_MIX_LPF_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a strobe; latches samples and volumes on strobe
// ST_MAC  | one channel per cycle: acc += sample * (8 + vol), 4 cycles
// ST_OUT  | shift by 3, clamp, drive outputs (or load the filter state)
// ST_LPF  | filter build only: drive outputs from the filter state
module bubsys_snd_mixer #(
  parameter int SAT_MAX = 32767,
  parameter int SAT_MIN = -32768
) (
  input  logic               i_EMU_CLK72M,
  input  logic               i_EMU_RST_n,
  bubsys_snd_mixer_if.slave  mix
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_LPF  = 2'd3
  } state_t;

  localparam logic signed [22:0] SAT_MAX_W = 23'(SAT_MAX);
  localparam logic signed [22:0] SAT_MIN_W = 23'(SAT_MIN);

  state_t            state_q;
  logic [1:0]        ch_q;
  logic [3:0][15:0]  smp_q;
  logic [15:0]       vol_q;
  logic signed [22:0] acc_q;
  logic [15:0]       snd_q;
  logic              valid_q;
  logic              ovr_q;

  logic [15:0]        smp_sel;
  logic [3:0]         vol_sel;
  logic [4:0]         gain;
  logic signed [22:0] prod;
  logic signed [22:0] acc_d;
  logic signed [22:0] shr;
  logic [15:0]        sat_d;

  always_comb begin
    smp_sel = smp_q[ch_q];
    vol_sel = vol_q[{ch_q, 2'b00} +: 4];
    // 8 + signed code is just the code with its sign bit inverted
    gain    = {1'b0, ~vol_sel[3], vol_sel[2:0]};
    prod    = $signed({{7{smp_sel[15]}}, smp_sel}) * $signed({18'd0, gain});
    acc_d   = acc_q + prod;
    shr     = acc_q >>> 3;
    if (shr > SAT_MAX_W) begin
      sat_d = SAT_MAX_W[15:0];
    end else if (shr < SAT_MIN_W) begin
      sat_d = SAT_MIN_W[15:0];
    end else begin
      sat_d = shr[15:0];
    end
  end

`ifdef BUBSYS_MIX_LPF_EN
  logic [15:0]        y_q;
  logic signed [16:0] lpf_diff;
  logic signed [16:0] lpf_y;

  always_comb begin
    lpf_diff = $signed({sat_d[15], sat_d}) - $signed({y_q[15], y_q});
    lpf_y    = $signed({y_q[15], y_q}) + (lpf_diff >>> 2);
  end
`endif

  always_ff @(posedge i_EMU_CLK72M) begin
    if (!i_EMU_RST_n) begin
      state_q <= ST_IDLE;
      ch_q    <= 2'd0;
      smp_q   <= '0;
      vol_q   <= '0;
      acc_q   <= '0;
      snd_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef BUBSYS_MIX_LPF_EN
      y_q     <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (mix.i_SAMPLE_CEN && (state_q != ST_IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (mix.i_SAMPLE_CEN) begin
            smp_q   <= {mix.i_CH3, mix.i_CH2, mix.i_CH1, mix.i_CH0};
            vol_q   <= mix.i_VOL;
            acc_q   <= '0;
            ch_q    <= 2'd0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          ch_q  <= ch_q + 2'd1;
          if (ch_q == 2'd3) begin
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
`ifdef BUBSYS_MIX_LPF_EN
          y_q     <= lpf_y[15:0];
          state_q <= ST_LPF;
`else
          snd_q   <= sat_d;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
`endif
        end
`ifdef BUBSYS_MIX_LPF_EN
        ST_LPF: begin
          snd_q   <= y_q;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mix.o_SND_L     = snd_q;
  assign mix.o_SND_R     = snd_q;
  assign mix.o_SND_VALID = valid_q;
  assign mix.o_OVERRUN   = ovr_q;

endmodule

// File: tb/tb_bubsys_snd_mixer.sv
// Randomized self-checking bench for bubsys_snd_mixer against an integer model
// of the gain/sum/shift/clamp rules (and the output low-pass when enabled).
module tb_bubsys_snd_mixer;

`ifdef BUBSYS_MIX_LPF_EN
  localparam int LAT     = 6;
  localparam int SPACING = 7;
`else
  localparam int LAT     = 5;
  localparam int SPACING = 6;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   y_mdl    = 0;

  bubsys_snd_mixer_if bus ();

  bubsys_snd_mixer #(.SAT_MAX(32767), .SAT_MIN(-32768)) dut (
    .i_EMU_CLK72M (clk),
    .i_EMU_RST_n  (rst_n),
    .mix          (bus)
  );

  always #5 clk = ~clk;

  function automatic int mix_sum(input int c[4], input logic [15:0] v);
    int acc = 0;
    int code;
    int r;
    for (int i = 0; i < 4; i++) begin
      code = int'(v[4*i +: 4]);
      if (code > 7) code -= 16;
      acc += c[i] * (8 + code);
    end
    r = acc >>> 3;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int expect_out(input int r);
`ifdef BUBSYS_MIX_LPF_EN
    y_mdl = y_mdl + ((r - y_mdl) >>> 2);
    return y_mdl;
`else
    return r;
`endif
  endfunction

  task automatic scramble();
    bus.i_CH0 = 16'($urandom);
    bus.i_CH1 = 16'($urandom);
    bus.i_CH2 = 16'($urandom);
    bus.i_CH3 = 16'($urandom);
    bus.i_VOL = 16'($urandom);
  endtask

  task automatic drive(input int c[4], input logic [15:0] v);
    bus.i_CH0 = 16'(c[0]);
    bus.i_CH1 = 16'(c[1]);
    bus.i_CH2 = 16'(c[2]);
    bus.i_CH3 = 16'(c[3]);
    bus.i_VOL = v;
  endtask

  task automatic rand_chans(output int c[4]);
    logic [15:0] r16;
    for (int i = 0; i < 4; i++) begin
      r16 = 16'($urandom);
      c[i] = int'($signed(r16));
    end
  endtask

  // Strobe one mix, scramble inputs after the latch, and observe the result.
  task automatic do_mix(input int c[4], input logic [15:0] v,
                        output int got_l, output int got_r,
                        output int npulse, output int pulse_k, output int held);
    drive(c, v);
    bus.i_SAMPLE_CEN = 1'b1;
    @(posedge clk); #1;
    bus.i_SAMPLE_CEN = 1'b0;
    scramble();
    npulse = 0; pulse_k = -1; got_l = 0; got_r = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      if (bus.o_SND_VALID) begin
        npulse++;
        pulse_k = k;
        got_l = int'($signed(bus.o_SND_L));
        got_r = int'($signed(bus.o_SND_R));
      end
    end
    held = int'($signed(bus.o_SND_L));
  endtask

  task automatic test_reset();
    int npulse = 0;
    rst_n = 1'b0;
    bus.i_SAMPLE_CEN = 1'b1;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_SND_L !== 16'd0) begin failures++; $display("FAIL reset_l got=%0h want=0", bus.o_SND_L); end
    checks++; if (bus.o_SND_R !== 16'd0) begin failures++; $display("FAIL reset_r got=%0h want=0", bus.o_SND_R); end
    checks++; if (bus.o_SND_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.o_SND_VALID); end
    checks++; if (bus.o_OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b want=0", bus.o_OVERRUN); end
    rst_n = 1'b1;
    bus.i_SAMPLE_CEN = 1'b0;
    y_mdl = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.o_SND_VALID) npulse++;
    end
    checks++; if (npulse !== 0) begin failures++; $display("FAIL strobe_in_reset pulses got=%0d want=0", npulse); end
    checks++; if (bus.o_OVERRUN !== 1'b0) begin failures++; $display("FAIL strobe_in_reset_ovr got=%b want=0", bus.o_OVERRUN); end
  endtask

  task automatic test_directed();
    int          tc[5][4];
    logic [15:0] tv[5];
    int          c[4];
    int          exp_v, gl, gr, np, pk, hd;
    tc[0] = '{1000, 1000, 1000, 1000};       tv[0] = 16'h0000;
    tc[1] = '{800, 0, 20000, 0};             tv[1] = 16'h0807;
    tc[2] = '{30000, 30000, 30000, 30000};   tv[2] = 16'h7777;
    tc[3] = '{-30000, -30000, -30000, -30000}; tv[3] = 16'h7777;
    tc[4] = '{-3, 0, 0, 0};                  tv[4] = 16'h0001;
    for (int t = 0; t < 5; t++) begin
      c = tc[t];
      exp_v = expect_out(mix_sum(c, tv[t]));
      do_mix(c, tv[t], gl, gr, np, pk, hd);
      checks++; if (np !== 1) begin failures++; $display("FAIL dir%0d_pulses got=%0d want=1", t, np); end
      checks++; if (pk !== LAT) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", t, pk, LAT); end
      checks++; if (gl !== exp_v) begin failures++; $display("FAIL dir%0d_l got=%0d want=%0d", t, gl, exp_v); end
      checks++; if (gr !== exp_v) begin failures++; $display("FAIL dir%0d_r got=%0d want=%0d", t, gr, exp_v); end
      checks++; if (hd !== exp_v) begin failures++; $display("FAIL dir%0d_held got=%0d want=%0d", t, hd, exp_v); end
    end
  endtask

  task automatic test_random();
    int          c[4];
    logic [15:0] v;
    int          exp_v, gl, gr, np, pk, hd;
    for (int t = 0; t < 40; t++) begin
      rand_chans(c);
      v = 16'($urandom);
      exp_v = expect_out(mix_sum(c, v));
      do_mix(c, v, gl, gr, np, pk, hd);
      checks++; if (np !== 1 || pk !== LAT) begin failures++; $display("FAIL rnd%0d_timing pulses=%0d at=%0d want 1 at %0d", t, np, pk, LAT); end
      checks++; if (gl !== exp_v || gr !== exp_v) begin failures++; $display("FAIL rnd%0d_value got l=%0d r=%0d want=%0d", t, gl, gr, exp_v); end
    end
  endtask

  task automatic test_overrun();
    int          ca[4], cb[4], cc[4];
    logic [15:0] va, vb, vc;
    int          exp_a, exp_c, gl, gr, np, pk, hd;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    y_mdl = 0;
    rand_chans(ca); rand_chans(cb); rand_chans(cc);
    va = 16'($urandom); vb = 16'($urandom); vc = 16'($urandom);
    exp_a = expect_out(mix_sum(ca, va));
    drive(ca, va);
    bus.i_SAMPLE_CEN = 1'b1;
    @(posedge clk); #1;
    bus.i_SAMPLE_CEN = 1'b0;
    drive(cb, vb);
    np = 0; pk = -1; gl = 0;
    for (int k = 1; k < SPACING; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++; if (bus.o_OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b want=0", bus.o_OVERRUN); end
        bus.i_SAMPLE_CEN = 1'b1;
      end
      if (k == 2) begin
        bus.i_SAMPLE_CEN = 1'b0;
        scramble();
      end
      if (k == 3) begin
        checks++; if (bus.o_OVERRUN !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", bus.o_OVERRUN); end
      end
      if (bus.o_SND_VALID) begin
        np++;
        pk = k;
        gl = int'($signed(bus.o_SND_L));
      end
    end
    checks++; if (np !== 1 || pk !== LAT) begin failures++; $display("FAIL ovr_pulse pulses=%0d at=%0d want 1 at %0d", np, pk, LAT); end
    checks++; if (gl !== exp_a) begin failures++; $display("FAIL ovr_data got=%0d want=%0d", gl, exp_a); end
    exp_c = expect_out(mix_sum(cc, vc));
    do_mix(cc, vc, gl, gr, np, pk, hd);
    checks++; if (np !== 1 || pk !== LAT) begin failures++; $display("FAIL ovr_next_timing pulses=%0d at=%0d want 1 at %0d", np, pk, LAT); end
    checks++; if (gl !== exp_c) begin failures++; $display("FAIL ovr_next_data got=%0d want=%0d", gl, exp_c); end
    checks++; if (bus.o_OVERRUN !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", bus.o_OVERRUN); end
  endtask

  task automatic test_reset_mid_mix();
    int          c[4];
    logic [15:0] v;
    int          exp_v, gl, gr, np, pk, hd;
    int          npulse = 0;
    rand_chans(c);
    v = 16'($urandom);
    drive(c, v);
    bus.i_SAMPLE_CEN = 1'b1;
    @(posedge clk); #1;
    bus.i_SAMPLE_CEN = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    y_mdl = 0;
    if (bus.o_SND_VALID) npulse++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.o_SND_VALID) npulse++;
    end
    checks++; if (npulse !== 0) begin failures++; $display("FAIL midrst_pulses got=%0d want=0", npulse); end
    checks++; if (bus.o_SND_L !== 16'd0 || bus.o_SND_R !== 16'd0) begin failures++; $display("FAIL midrst_out got l=%0h r=%0h want=0", bus.o_SND_L, bus.o_SND_R); end
    checks++; if (bus.o_OVERRUN !== 1'b0) begin failures++; $display("FAIL midrst_ovr got=%b want=0", bus.o_OVERRUN); end
    rand_chans(c);
    v = 16'($urandom);
    exp_v = expect_out(mix_sum(c, v));
    do_mix(c, v, gl, gr, np, pk, hd);
    checks++; if (np !== 1 || pk !== LAT) begin failures++; $display("FAIL midrst_next_timing pulses=%0d at=%0d want 1 at %0d", np, pk, LAT); end
    checks++; if (gl !== exp_v || gr !== exp_v) begin failures++; $display("FAIL midrst_next_data got l=%0d r=%0d want=%0d", gl, gr, exp_v); end
  endtask

  initial begin
    bus.i_SAMPLE_CEN = 1'b0;
    bus.i_CH0 = '0;
    bus.i_CH1 = '0;
    bus.i_CH2 = '0;
    bus.i_CH3 = '0;
    bus.i_VOL = '0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_reset_mid_mix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
